sram_arbiter: RTL and testbench

//  Two-port arbiter/sequencer that shares the Avalon SRAM slave between two requesters,
//  e.g. port 0 = display reader, port 1 = image-pipeline writer. It accepts one command
//  per port, picks a winner, and holds read_n/write_n for a fixed access window. It

---
 rtl/sram_arbiter_if.sv | 28 ++
 rtl/sram_arbiter.sv | 138 +++++++++++++
 tb/tb_sram_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: two requester command/response ports plus the Avalon SRAM master bus
interface sram_arbiter_if #(parameter int ADDR_W = 18);
  logic              m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wdata, m0_rdata;
  logic [1:0]        m0_be_n;
  logic              m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wdata, m1_rdata;
  logic [1:0]        m1_be_n;
  logic              av_read_n, av_write_n, busy;
  logic [31:0]       av_address, av_writeData, av_readData;
  logic [1:0]        av_byteEnable_n;
  modport master (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_be_n,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_be_n,
    input  av_readData,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    output av_read_n, av_write_n, av_address, av_writeData, av_byteEnable_n, busy
  );
  modport slave (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_be_n,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_be_n,
    output av_readData,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    input  av_read_n, av_write_n, av_address, av_writeData, av_byteEnable_n, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one waitrequest-less Avalon SRAM slave between two requesters
// with fixed access/read-latency timing; every output is a register.
module sram_arbiter #(
  parameter int ADDR_W        = 18,
  parameter int ACCESS_CYCLES = 2,
  parameter int READ_LATENCY  = 1,
  parameter int FIXED_PRIO    = 0,
  parameter int MAX_STARVE    = 8
) (
  input logic            clk,
  input logic            rst_n,
  sram_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  localparam int CMAX = ACCESS_CYCLES > READ_LATENCY ? ACCESS_CYCLES : READ_LATENCY;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int SW   = $clog2(MAX_STARVE + 1) > 0 ? $clog2(MAX_STARVE + 1) : 1;
  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [SW-1:0]     starve, starve_nx;
  logic              cur, cur_nx, last_grant, last_nx, cap;
  logic              read_n, read_nx, write_n, write_nx, busy, busy_nx;
  logic [31:0]       address, addr_nx, wdata, wdata_nx, rdata0, rdata0_nx, rdata1, rdata1_nx;
  logic [1:0]        be_n, be_nx, gnt, gnt_nx, rvalid, rvalid_nx;
  logic              tie, win, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [1:0]        sel_be;
  // a tie in fixed-priority mode goes to port 1 only once it has lost MAX_STARVE ties in a row
  assign tie       = bus.m0_req & bus.m1_req;
  assign win       = tie ? (FIXED_PRIO != 0 ? starve == SW'(MAX_STARVE) : ~last_grant) : bus.m1_req;
  assign sel_we    = win ? bus.m1_we : bus.m0_we;
  assign sel_addr  = win ? bus.m1_addr : bus.m0_addr;
  assign sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;
  assign sel_be    = win ? bus.m1_be_n : bus.m0_be_n;
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    starve_nx = starve;
    cur_nx    = cur;
    last_nx   = last_grant;
    read_nx   = read_n;
    write_nx  = write_n;
    addr_nx   = address;
    wdata_nx  = wdata;
    be_nx     = be_n;
    rdata0_nx = rdata0;
    rdata1_nx = rdata1;
    gnt_nx    = 2'b00;
    rvalid_nx = 2'b00;
    cap       = 1'b0;
    case (state)
      IDLE: if (bus.m0_req | bus.m1_req) begin
        state_nx  = ACCESS;
        cnt_nx    = '0;
        cur_nx    = win;
        last_nx   = win;
        gnt_nx    = win ? 2'b10 : 2'b01;
        read_nx   = sel_we;
        write_nx  = ~sel_we;
        addr_nx   = 32'(sel_addr);
        wdata_nx  = sel_wdata;
        be_nx     = sel_be;
        starve_nx = win ? '0 : (tie && starve != SW'(MAX_STARVE)) ? starve + 1'b1 : starve;
      end
      ACCESS: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == CW'(ACCESS_CYCLES - 1)) begin
          read_nx  = 1'b1;
          write_nx = 1'b1;
          cnt_nx   = '0;
          state_nx = !write_n ? IDLE : (READ_LATENCY == 0 ? RESP : WAIT);
          cap      = write_n && READ_LATENCY == 0;
        end
      end
      WAIT: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == CW'(READ_LATENCY - 1)) begin
          state_nx = RESP;
          cap      = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (cap) begin
      rvalid_nx = cur ? 2'b10 : 2'b01;
      rdata0_nx = cur ? rdata0 : bus.av_readData;
      rdata1_nx = cur ? bus.av_readData : rdata1;
    end
    busy_nx = state_nx != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      starve     <= '0;
      cur        <= 1'b0;
      last_grant <= 1'b1;
      read_n     <= 1'b1;
      write_n    <= 1'b1;
      busy       <= 1'b0;
      address    <= '0;
      wdata      <= '0;
      be_n       <= 2'b11;
      rdata0     <= '0;
      rdata1     <= '0;
      gnt        <= '0;
      rvalid     <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      starve     <= starve_nx;
      cur        <= cur_nx;
      last_grant <= last_nx;
      read_n     <= read_nx;
      write_n    <= write_nx;
      busy       <= busy_nx;
      address    <= addr_nx;
      wdata      <= wdata_nx;
      be_n       <= be_nx;
      rdata0     <= rdata0_nx;
      rdata1     <= rdata1_nx;
      gnt        <= gnt_nx;
      rvalid     <= rvalid_nx;
    end
  assign bus.m0_gnt          = gnt[0];
  assign bus.m1_gnt          = gnt[1];
  assign bus.m0_rvalid       = rvalid[0];
  assign bus.m1_rvalid       = rvalid[1];
  assign bus.m0_rdata        = rdata0;
  assign bus.m1_rdata        = rdata1;
  assign bus.av_read_n       = read_n;
  assign bus.av_write_n      = write_n;
  assign bus.av_address      = address;
  assign bus.av_writeData    = wdata;
  assign bus.av_byteEnable_n = be_n;
  assign bus.busy            = busy;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized checks of sram_arbiter against a transaction-level
// model (grant order, read data from a reference memory, response cycle, strobe width).
module tb_sram_arbiter;
  localparam int A = 2, L = 1, MS = 8;
  typedef struct {int port; logic [31:0] data; int c;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter_if #(.ADDR_W(18)) ra();
  sram_arbiter_if #(.ADDR_W(18)) fa();
  sram_arbiter #(.ADDR_W(18), .ACCESS_CYCLES(A), .READ_LATENCY(L), .FIXED_PRIO(0), .MAX_STARVE(MS))
    u_rr (.clk(clk), .rst_n(rst_n), .bus(ra.master));
  sram_arbiter #(.ADDR_W(18), .ACCESS_CYCLES(A), .READ_LATENCY(L), .FIXED_PRIO(1), .MAX_STARVE(MS))
    u_fp (.clk(clk), .rst_n(rst_n), .bus(fa.master));

  // SRAM slave model: preloaded with an address-derived pattern while reset is held
  logic [31:0] mem_r [256];
  assign ra.av_readData = mem_r[ra.av_address[7:0]];
  always @(posedge clk)
    if (!rst_n) for (int i = 0; i < 256; i++) mem_r[i] <= 32'hA5A5_0000 | 32'(i);
    else if (!ra.av_write_n) mem_r[ra.av_address[7:0]] <= ra.av_writeData;
  assign fa.av_readData = 32'h0F0F_0F0F;

  logic        sw_req;
  logic [17:0] sw_addr;
  int          sw_wid [9], sw_lat [9];
  logic [31:0] sw_dat [9];
  logic [8:0]  sw_dn;
  for (genvar i = 0; i < 9; i++) begin : g_sw
    sram_arbiter_if #(.ADDR_W(18)) s_if();
    sram_arbiter #(.ADDR_W(18), .ACCESS_CYCLES(i / 3 + 1), .READ_LATENCY(i % 3), .FIXED_PRIO(0), .MAX_STARVE(MS))
      u_sw (.clk(clk), .rst_n(rst_n), .bus(s_if.master));
    assign s_if.m0_req = sw_req;
    assign s_if.m0_we = 1'b0;
    assign s_if.m0_addr = sw_addr;
    assign s_if.m0_wdata = '0;
    assign s_if.m0_be_n = 2'b11;
    assign s_if.m1_req = 1'b0;
    assign s_if.m1_we = 1'b0;
    assign s_if.m1_addr = '0;
    assign s_if.m1_wdata = '0;
    assign s_if.m1_be_n = 2'b11;
    assign s_if.av_readData = {8'(i), 6'd0, s_if.av_address[17:0]};
    int t, wid, lat;
    logic on, dn;
    logic [31:0] dat;
    always @(negedge clk)
      if (!rst_n) begin
        on = 1'b0; dn = 1'b0; t = 0; wid = 0; lat = 0; dat = '0;
      end else if (s_if.m0_gnt) begin
        on = 1'b1; t = 0; wid = s_if.av_read_n ? 0 : 1;
      end else if (on) begin
        t++;
        if (!s_if.av_read_n) wid++;
        if (s_if.m0_rvalid) begin
          lat = t; dat = s_if.m0_rdata; dn = 1'b1; on = 1'b0;
        end
      end
    assign sw_wid[i] = wid;
    assign sw_lat[i] = lat;
    assign sw_dat[i] = dat;
    assign sw_dn[i]  = dn;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] ref_m [int];
  function automatic logic [31:0] ref_rd(input int a);
    return ref_m.exists(a) ? ref_m[a] : (32'hA5A5_0000 | 32'(a));
  endfunction

  bit          pend [2], pwe [2];
  logic [7:0]  paddr [2];
  logic [31:0] pdat [2], rd_hold [2];
  exp_t        rq [$];
  exp_t        e;
  int          last_m, gcyc, gap_min, run, w, s, n;
  logic [1:0]  g, rv;

  initial begin
    ra.m0_req = 0; ra.m0_we = 0; ra.m0_addr = '0; ra.m0_wdata = '0; ra.m0_be_n = 2'b11;
    ra.m1_req = 0; ra.m1_we = 0; ra.m1_addr = '0; ra.m1_wdata = '0; ra.m1_be_n = 2'b11;
    fa.m0_req = 0; fa.m0_we = 0; fa.m0_addr = 18'h4; fa.m0_wdata = '0; fa.m0_be_n = 2'b11;
    fa.m1_req = 0; fa.m1_we = 0; fa.m1_addr = 18'h8; fa.m1_wdata = '0; fa.m1_be_n = 2'b11;
    sw_req = 0; sw_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_read_n", ra.av_read_n, 1);
    chk("rst_write_n", ra.av_write_n, 1);
    chk("rst_address", ra.av_address, 0);
    chk("rst_wdata", ra.av_writeData, 0);
    chk("rst_be_n", ra.av_byteEnable_n, 2'b11);
    chk("rst_busy", ra.busy, 0);
    chk("rst_gnt", {ra.m1_gnt, ra.m0_gnt}, 0);
    chk("rst_rvalid", {ra.m1_rvalid, ra.m0_rvalid}, 0);
    chk("rst_rdata", ra.m0_rdata | ra.m1_rdata, 0);
    rst_n = 1;
    @(negedge clk);
    // m0 write then read-back of the same word
    ra.m0_req = 1; ra.m0_we = 1; ra.m0_addr = 18'h10; ra.m0_wdata = 32'hDEADBEEF; ra.m0_be_n = 2'b00;
    @(negedge clk);
    chk("t1_gnt", ra.m0_gnt, 1);
    chk("t1_write_n_c1", ra.av_write_n, 0);
    chk("t1_read_n_c1", ra.av_read_n, 1);
    chk("t1_address", ra.av_address, 32'h10);
    ra.m0_req = 0;
    @(negedge clk);
    chk("t1_gnt_pulse", ra.m0_gnt, 0);
    chk("t1_write_n_c2", ra.av_write_n, 0);
    @(negedge clk);
    chk("t1_write_n_c3", ra.av_write_n, 1);
    chk("t1_idle_c3", ra.busy, 0);
    ra.m0_req = 1; ra.m0_we = 0;
    @(negedge clk);
    chk("t1r_gnt", ra.m0_gnt, 1);
    chk("t1r_read_n_c1", ra.av_read_n, 0);
    ra.m0_req = 0;
    @(negedge clk);
    chk("t1r_read_n_c2", ra.av_read_n, 0);
    @(negedge clk);
    chk("t1r_read_n_c3", ra.av_read_n, 1);
    chk("t1r_rvalid_c3", ra.m0_rvalid, 0);
    @(negedge clk);
    chk("t1r_rvalid_c4", ra.m0_rvalid, 1);
    chk("t1r_rdata", ra.m0_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1r_rvalid_c5", ra.m0_rvalid, 0);
    chk("t1r_idle_c5", ra.busy, 0);
    // m1 write with partial byte enables
    ra.m1_req = 1; ra.m1_we = 1; ra.m1_addr = 18'h20; ra.m1_wdata = 32'h1234_5678; ra.m1_be_n = 2'b10;
    @(negedge clk);
    chk("t4_gnt", {ra.m1_gnt, ra.m0_gnt}, 2'b10);
    ra.m1_req = 0;
    for (int c = 1; c <= 2; c++) begin
      chk($sformatf("t4_be_n_c%0d", c), ra.av_byteEnable_n, 2'b10);
      chk($sformatf("t4_wdata_c%0d", c), ra.av_writeData, 32'h1234_5678);
      chk($sformatf("t4_write_n_c%0d", c), ra.av_write_n, 0);
      chk($sformatf("t4_read_n_c%0d", c), ra.av_read_n, 1);
      @(negedge clk);
    end
    chk("t4_write_n_end", ra.av_write_n, 1);
    // continuous (phase 0) then sparse random (phase 1) traffic against the reference model
    last_m = 1; gcyc = -1; run = 0; gap_min = 0;
    rd_hold[0] = 32'hDEADBEEF; rd_hold[1] = '0;
    pend[0] = 0; pend[1] = 0; pwe[0] = 0; pwe[1] = 0;
    for (int ph = 0; ph < 2; ph++)
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        g = {ra.m1_gnt, ra.m0_gnt};
        if (g != 2'b00) begin
          w = (pend[0] && pend[1]) ? (last_m == 0 ? 1 : 0) : (pend[1] ? 1 : 0);
          chk("rr_grant", 32'(g), w == 1 ? 32'd2 : 32'd1);
          if (ph == 0 && gcyc >= 0) chk("rr_gap", cyc - gcyc, gap_min);
          gcyc = cyc; last_m = w; gap_min = pwe[w] ? A + 1 : A + L + 2;
          if (pwe[w]) ref_m[int'(paddr[w])] = pdat[w];
          else begin
            e = '{w, ref_rd(int'(paddr[w])), cyc + A + L};
            rq.push_back(e);
          end
          pend[w] = 0;
        end
        rv = {ra.m1_rvalid, ra.m0_rvalid};
        if (rv != 2'b00) begin
          if (rq.size() == 0) chk("rr_spurious_rvalid", 32'(rv), 0);
          else begin
            e = rq.pop_front();
            chk("rr_rvalid_port", 32'(rv), e.port == 1 ? 32'd2 : 32'd1);
            chk("rr_rvalid_cycle", cyc, e.c);
            rd_hold[e.port] = e.data;
            chk("rr_rdata0", ra.m0_rdata, rd_hold[0]);
            chk("rr_rdata1", ra.m1_rdata, rd_hold[1]);
          end
        end
        if (!ra.av_read_n || !ra.av_write_n) run++;
        else if (run != 0) begin
          chk("rr_strobe_width", run, A);
          run = 0;
        end
        for (int p = 0; p < 2; p++)
          if (!pend[p] && k < 270 && (ph == 0 || $urandom_range(0, 2) == 0)) begin
            pend[p] = 1; pwe[p] = 1'($urandom_range(0, 1));
            paddr[p] = 8'($urandom_range(0, 15)); pdat[p] = $urandom;
          end
        ra.m0_req = pend[0]; ra.m0_we = pwe[0]; ra.m0_addr = 18'(paddr[0]); ra.m0_wdata = pdat[0]; ra.m0_be_n = 2'b00;
        ra.m1_req = pend[1]; ra.m1_we = pwe[1]; ra.m1_addr = 18'(paddr[1]); ra.m1_wdata = pdat[1]; ra.m1_be_n = 2'b00;
      end
    chk("rr_drain", rq.size() + int'(pend[0]) + int'(pend[1]), 0);
    ra.m0_req = 0; ra.m1_req = 0;
    repeat (2) @(negedge clk);
    // reset during WAIT of an m0 read, then during ACCESS of an m1 write
    ra.m0_req = 1; ra.m0_we = 0; ra.m0_addr = 18'h10;
    @(negedge clk);
    ra.m0_req = 0;
    repeat (2) @(negedge clk);
    chk("t5_in_wait_busy", ra.busy, 1);
    rst_n = 0;
    #1;
    chk("t5_read_n", ra.av_read_n, 1);
    chk("t5_write_n", ra.av_write_n, 1);
    chk("t5_busy", ra.busy, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t5_no_rvalid", ra.m0_rvalid, 0);
      chk("t5_rdata_cleared", ra.m0_rdata, 0);
    end
    rst_n = 1;
    ra.m1_req = 1; ra.m1_we = 1; ra.m1_addr = 18'h30; ra.m1_wdata = 32'hCAFE_F00D; ra.m1_be_n = 2'b00;
    @(negedge clk);
    chk("t5w_write_n_low", ra.av_write_n, 0);
    ra.m1_req = 0;
    rst_n = 0;
    #1;
    chk("t5w_write_n", ra.av_write_n, 1);
    chk("t5w_busy", ra.busy, 0);
    chk("t5w_gnt", ra.m1_gnt, 0);
    @(negedge clk);
    rst_n = 1;
    ra.m0_req = 1; ra.m0_we = 0; ra.m0_addr = 18'h1;
    ra.m1_req = 1; ra.m1_we = 0; ra.m1_addr = 18'h2;
    @(negedge clk);
    chk("t5_tie_after_reset", {ra.m1_gnt, ra.m0_gnt}, 2'b01);
    ra.m0_req = 0; ra.m1_req = 0;
    repeat (6) @(negedge clk);
    // fixed priority: both ports hold req high, grant order follows the starvation rule
    fa.m0_req = 1; fa.m1_req = 1;
    s = 0; n = 0;
    for (int k = 0; k < 400 && n < 20; k++) begin
      @(negedge clk);
      g = {fa.m1_gnt, fa.m0_gnt};
      if (g != 2'b00) begin
        w = (s >= MS) ? 1 : 0;
        chk($sformatf("fp_grant_%0d", n), 32'(g), w == 1 ? 32'd2 : 32'd1);
        s = (w == 1) ? 0 : (s + 1 > MS ? MS : s + 1);
        n++;
      end
    end
    chk("fp_grant_count", n, 20);
    fa.m0_req = 0; fa.m1_req = 0;
    repeat (6) @(negedge clk);
    // ACCESS_CYCLES x READ_LATENCY sweep, one read on every instance
    sw_addr = 18'h155; sw_req = 1;
    @(negedge clk);
    sw_req = 0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("sw%0d_done", i), sw_dn[i], 1);
      chk($sformatf("sw%0d_strobe_width", i), sw_wid[i], i / 3 + 1);
      chk($sformatf("sw%0d_gnt_to_rvalid", i), sw_lat[i], i / 3 + 1 + i % 3);
      chk($sformatf("sw%0d_rdata", i), sw_dat[i], {8'(i), 6'd0, 18'h155});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
